// File: rtl/lsu_controller.sv
// lsu_controller: load/store sequencer between the execute stage and a
// word-addressed data memory port using a req/gnt/rvalid handshake.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   start                 a memory op is presented this cycle
//   is_load, mem_write    op kind (is_load wins if both are set)
//   load_type, store_type access width: 000 byte, 001 half, others word
//   load_unsigned         zero-extend the load result
//   addr, wdata           byte address and store data
//   stall                 hold the pipeline while the access is in flight
//   done                  one-cycle completion pulse
//   rdata_out             extended load result, held until the next done
//   misalign_err          one-cycle pulse: access rejected
//   bus_err               one-cycle pulse: memory did not respond in time
//   mem_req/we/addr/be/wdata   request side of the memory port
//   mem_gnt, mem_rvalid, mem_rdata   response side of the memory port
//
// Build option: define LSU_MISALIGNED_SPLIT_EN to perform misaligned
// accesses (split into two beats when they cross a word). Without it,
// misaligned halves/words are rejected with misalign_err.
module lsu_controller #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        is_load,
    input  logic        mem_write,
    input  logic [2:0]  load_type,
    input  logic        load_unsigned,
    input  logic [2:0]  store_type,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata_out,
    output logic        misalign_err,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, DONE} state_t;

    state_t      state_q, state_d;
    logic        load_q, load_d;
    logic [2:0]  type_q, type_d;
    logic        uns_q, uns_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] cnt_q, cnt_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        done_q, done_d;
    logic        misalign_q, misalign_d;
    logic        bus_err_q, bus_err_d;
    logic [31:0] rdata_q, rdata_d;
`ifdef LSU_MISALIGNED_SPLIT_EN
    // Second-beat context: high byte enables, original store data, low word.
    logic [3:0]  be_hi_q, be_hi_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] lo_q, lo_d;
`endif

    logic [2:0]  in_type;
    logic [3:0]  in_mask;
    logic [7:0]  in_window;
    logic        in_reject;
    logic        timed_out;

    // Byte mask for an access width code, before lane shifting.
    function automatic logic [3:0] size_mask(input logic [2:0] ty);
        case (ty)
            3'b000:  size_mask = 4'b0001;
            3'b001:  size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
    endfunction

    // Pick the addressed bytes out of the {hi,lo} word pair and extend them.
    function automatic logic [31:0] extract(input logic [63:0] pair,
                                            input logic [1:0]  off,
                                            input logic [2:0]  ty,
                                            input logic        uns);
        logic [31:0] sh;
        sh = 32'(pair >> {off, 3'b000});
        case (ty)
            3'b000:  extract = uns ? {24'h0, sh[7:0]}  : {{24{sh[7]}},  sh[7:0]};
            3'b001:  extract = uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: extract = sh;
        endcase
    endfunction

    assign in_type   = is_load ? load_type : store_type;
    assign in_mask   = size_mask(in_type);
    // 8-bit window: bits [7:4] set means the access spills into the next word.
    assign in_window = {4'b0000, in_mask} << addr[1:0];

`ifdef LSU_MISALIGNED_SPLIT_EN
    assign in_reject = 1'b0;
`else
    // A word at off!=0 always crosses; a half is rejected on any odd offset.
    assign in_reject = (in_window[7:4] != 4'b0000) || (in_type == 3'b001 && addr[0]);
`endif

    assign timed_out = (TIMEOUT_CYCLES != 0) && (cnt_q >= 32'(TIMEOUT_CYCLES) - 32'd1);

    // Combinational stall covers the cycle where start is seen in IDLE.
    assign stall = rst_n && ((state_q != IDLE && state_q != DONE) ||
                             (state_q == IDLE && start && (is_load || mem_write)));

    assign done         = done_q;
    assign rdata_out    = rdata_q;
    assign misalign_err = misalign_q;
    assign bus_err      = bus_err_q;
    assign mem_req      = mem_req_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_be       = mem_be_q;
    assign mem_wdata    = mem_wdata_q;

    // Next-state and next-output computation. Request outputs are computed
    // for the state being entered so they come straight from flops.
    always_comb begin
        state_d     = state_q;
        load_d      = load_q;
        type_d      = type_q;
        uns_d       = uns_q;
        off_d       = off_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        done_d      = 1'b0;
        misalign_d  = 1'b0;
        bus_err_d   = 1'b0;
`ifdef LSU_MISALIGNED_SPLIT_EN
        be_hi_d     = be_hi_q;
        wdata_d     = wdata_q;
        lo_d        = lo_q;
`endif

        if ((state_q inside {REQ0, WAIT0, REQ1, WAIT1}) && cnt_q != '1) begin
            cnt_d = cnt_q + 32'd1;
        end

        case (state_q)
            IDLE: begin
                if (start && (is_load || mem_write)) begin
                    load_d = is_load;
                    type_d = in_type;
                    uns_d  = load_unsigned;
                    off_d  = addr[1:0];
`ifdef LSU_MISALIGNED_SPLIT_EN
                    be_hi_d = in_window[7:4];
                    wdata_d = wdata;
`endif
                    if (in_reject) begin
                        misalign_d = 1'b1;
                    end else begin
                        state_d     = REQ0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = !is_load;
                        mem_addr_d  = {addr[31:2], 2'b00};
                        mem_be_d    = in_window[3:0];
                        mem_wdata_d = wdata << {addr[1:0], 3'b000};
                    end
                end
            end
            REQ0, REQ1: begin
                if (mem_gnt) begin
                    state_d   = (state_q == REQ0) ? WAIT0 : WAIT1;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                end else if (timed_out) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    bus_err_d = 1'b1;
                end
            end
            WAIT0: begin
                if (mem_rvalid) begin
`ifdef LSU_MISALIGNED_SPLIT_EN
                    lo_d = mem_rdata;
                    if (be_hi_q != 4'b0000) begin
                        state_d     = REQ1;
                        mem_req_d   = 1'b1;
                        mem_we_d    = !load_q;
                        mem_addr_d  = mem_addr_q + 32'd4;
                        mem_be_d    = be_hi_q;
                        mem_wdata_d = wdata_q >> (6'd32 - {1'b0, off_q, 3'b000});
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        if (load_q) rdata_d = extract({32'h0, mem_rdata}, off_q, type_q, uns_q);
                    end
`else
                    state_d = DONE;
                    done_d  = 1'b1;
                    if (load_q) rdata_d = extract({32'h0, mem_rdata}, off_q, type_q, uns_q);
`endif
                end else if (timed_out) begin
                    state_d   = IDLE;
                    bus_err_d = 1'b1;
                end
            end
`ifdef LSU_MISALIGNED_SPLIT_EN
            WAIT1: begin
                if (mem_rvalid) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    if (load_q) rdata_d = extract({mem_rdata, lo_q}, off_q, type_q, uns_q);
                end else if (timed_out) begin
                    state_d   = IDLE;
                    bus_err_d = 1'b1;
                end
            end
`endif
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
            end
        endcase

        // The timeout counter measures time spent in the current state.
        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    // All state and registered outputs; reset drops mem_req immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            load_q      <= 1'b0;
            type_q      <= 3'b000;
            uns_q       <= 1'b0;
            off_q       <= 2'b00;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            done_q      <= 1'b0;
            misalign_q  <= 1'b0;
            bus_err_q   <= 1'b0;
`ifdef LSU_MISALIGNED_SPLIT_EN
            be_hi_q     <= '0;
            wdata_q     <= '0;
            lo_q        <= '0;
`endif
        end else begin
            state_q     <= state_d;
            load_q      <= load_d;
            type_q      <= type_d;
            uns_q       <= uns_d;
            off_q       <= off_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            done_q      <= done_d;
            misalign_q  <= misalign_d;
            bus_err_q   <= bus_err_d;
`ifdef LSU_MISALIGNED_SPLIT_EN
            be_hi_q     <= be_hi_d;
            wdata_q     <= wdata_d;
            lo_q        <= lo_d;
`endif
        end
    end

endmodule

// File: tb/tb_lsu_controller.sv
// Directed testbench for lsu_controller: drives memory ops, plays the memory
// side of the handshake with configurable grant delay, and compares the
// results against hand-computed values.
module tb_lsu_controller;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        is_load;
    logic        mem_write;
    logic [2:0]  load_type;
    logic        load_unsigned;
    logic [2:0]  store_type;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        done;
    logic [31:0] rdata_out;
    logic        misalign_err;
    logic        bus_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int testsRun;
    int testsFailed;

    // Results of the latest applyStimulus call.
    int          resDoneCyc;
    int          resMisCyc;
    int          resBusCyc;
    logic [31:0] resRdata;
    int          stallCnt;
    int          beats;
    logic        stableOk;
    logic        termStall;
    logic [31:0] beatAddr  [0:3];
    logic [3:0]  beatBe    [0:3];
    logic [31:0] beatWdata [0:3];
    logic        beatWe    [0:3];

    lsu_controller #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .is_load(is_load),
        .mem_write(mem_write), .load_type(load_type), .load_unsigned(load_unsigned),
        .store_type(store_type), .addr(addr), .wdata(wdata), .stall(stall),
        .done(done), .rdata_out(rdata_out), .misalign_err(misalign_err),
        .bus_err(bus_err), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Count one comparison and report it when it does not match.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Issue one op and act as the memory until done, misalign_err or bus_err.
    // Cycle 0 is the start cycle; later cycles are counted at each negedge.
    task automatic applyStimulus(input logic ld, input logic st, input logic [2:0] ty,
                                 input logic uns, input logic [31:0] a,
                                 input logic [31:0] wd, input int gntDelay,
                                 input logic rvEn, input logic [31:0] w0,
                                 input logic [31:0] w1);
        int   reqCnt;
        logic rvNext;
        logic finished;
        resDoneCyc = -1; resMisCyc = -1; resBusCyc = -1; resRdata = '0;
        beats = 0; stableOk = 1'b1; reqCnt = 0; rvNext = 1'b0; finished = 1'b0;
        termStall = 1'b1;
        @(negedge clk);
        start = 1'b1; is_load = ld; mem_write = st; load_type = ty; store_type = ty;
        load_unsigned = uns; addr = a; wdata = wd;
        #1;
        stallCnt = stall ? 1 : 0;
        @(posedge clk);
        #1;
        start = 1'b0; is_load = 1'b0; mem_write = 1'b0;
        for (int c = 1; c <= 60 && !finished; c++) begin
            @(negedge clk);
            mem_gnt = 1'b0;
            mem_rvalid = rvNext && rvEn;
            mem_rdata = (beats <= 1) ? w0 : w1;
            rvNext = 1'b0;
            if (done) begin
                resDoneCyc = c; resRdata = rdata_out; termStall = stall; finished = 1'b1;
            end else if (misalign_err) begin
                resMisCyc = c; termStall = stall; finished = 1'b1;
            end else if (bus_err) begin
                resBusCyc = c; termStall = stall; finished = 1'b1;
            end else begin
                if (stall) stallCnt++;
                if (mem_req) begin
                    if (beats < 4) begin
                        if (reqCnt == 0) begin
                            beatAddr[beats] = mem_addr; beatBe[beats] = mem_be;
                            beatWdata[beats] = mem_wdata; beatWe[beats] = mem_we;
                        end else if (mem_addr !== beatAddr[beats] || mem_be !== beatBe[beats] ||
                                     mem_wdata !== beatWdata[beats]) begin
                            stableOk = 1'b0;
                        end
                    end
                    reqCnt++;
                    if (reqCnt > gntDelay) begin
                        mem_gnt = 1'b1; beats++; reqCnt = 0; rvNext = 1'b1;
                    end
                end else if (reqCnt != 0) begin
                    stableOk = 1'b0;
                end
            end
        end
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
    endtask

    initial begin
        testsRun = 0; testsFailed = 0;
        clk = 1'b0; rst_n = 1'b1; start = 1'b0; is_load = 1'b0; mem_write = 1'b0;
        load_type = 3'b000; load_unsigned = 1'b0; store_type = 3'b000;
        addr = '0; wdata = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        #2 rst_n = 1'b0;
        #10;
        checkOutput("reset_stall", 32'(stall), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_rdata", rdata_out, 32'h0);
        checkOutput("reset_req", 32'(mem_req), 32'd0);
        checkOutput("reset_be", 32'(mem_be), 32'd0);
        checkOutput("reset_errs", 32'({misalign_err, bus_err}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // LW 0x100
        applyStimulus(1, 0, 3'b010, 0, 32'h100, 32'h0, 0, 1, 32'hDEADBEEF, 32'h0);
        checkOutput("lw_done_cyc", 32'(resDoneCyc), 32'd3);
        checkOutput("lw_rdata", resRdata, 32'hDEADBEEF);
        checkOutput("lw_be", 32'(beatBe[0]), 32'hF);
        checkOutput("lw_addr", beatAddr[0], 32'h100);
        checkOutput("lw_we", 32'(beatWe[0]), 32'd0);
        checkOutput("lw_stall_cycles", 32'(stallCnt), 32'd3);
        checkOutput("lw_stall_at_done", 32'(termStall), 32'd0);

        // LB / LBU 0x103
        applyStimulus(1, 0, 3'b000, 0, 32'h103, 32'h0, 0, 1, 32'h80FFFFFF, 32'h0);
        checkOutput("lb_be", 32'(beatBe[0]), 32'h8);
        checkOutput("lb_rdata", resRdata, 32'hFFFFFF80);
        applyStimulus(1, 0, 3'b000, 1, 32'h103, 32'h0, 0, 1, 32'h80FFFFFF, 32'h0);
        checkOutput("lbu_rdata", resRdata, 32'h00000080);

        // SH 0x102
        applyStimulus(0, 1, 3'b001, 0, 32'h102, 32'h0000ABCD, 0, 1, 32'h0, 32'h0);
        checkOutput("sh_we", 32'(beatWe[0]), 32'd1);
        checkOutput("sh_be", 32'(beatBe[0]), 32'hC);
        checkOutput("sh_wdata", beatWdata[0], 32'hABCD0000);
        checkOutput("sh_addr", beatAddr[0], 32'h100);
        checkOutput("sh_rdata_kept", resRdata, 32'h00000080);

        // LW with grant delayed 4 cycles
        applyStimulus(1, 0, 3'b010, 0, 32'h200, 32'h0, 4, 1, 32'h12345678, 32'h0);
        checkOutput("gnt4_done_cyc", 32'(resDoneCyc), 32'd7);
        checkOutput("gnt4_stable", 32'(stableOk), 32'd1);
        checkOutput("gnt4_stall_cycles", 32'(stallCnt), 32'd7);
        checkOutput("gnt4_rdata", resRdata, 32'h12345678);

        // LH / LHU
        applyStimulus(1, 0, 3'b001, 0, 32'h206, 32'h0, 0, 1, 32'hBEEF1234, 32'h0);
        checkOutput("lh_rdata", resRdata, 32'hFFFFBEEF);
        applyStimulus(1, 0, 3'b001, 1, 32'h204, 32'h0, 0, 1, 32'h1234F00D, 32'h0);
        checkOutput("lhu_rdata", resRdata, 32'h0000F00D);

        // SB 0x301, SW 0x400
        applyStimulus(0, 1, 3'b000, 0, 32'h301, 32'h123456A5, 0, 1, 32'h0, 32'h0);
        checkOutput("sb_be", 32'(beatBe[0]), 32'h2);
        checkOutput("sb_wdata", beatWdata[0], 32'h3456A500);
        applyStimulus(0, 1, 3'b010, 0, 32'h400, 32'hCAFEF00D, 0, 1, 32'h0, 32'h0);
        checkOutput("sw_be", 32'(beatBe[0]), 32'hF);
        checkOutput("sw_wdata", beatWdata[0], 32'hCAFEF00D);
        checkOutput("sw_rdata_kept", rdata_out, 32'h0000F00D);

        // Misaligned accesses
        applyStimulus(1, 0, 3'b010, 0, 32'h101, 32'h0, 0, 1, 32'h44332211, 32'h88776655);
`ifdef LSU_MISALIGNED_SPLIT_EN
        checkOutput("lw101_done_cyc", 32'(resDoneCyc), 32'd5);
        checkOutput("lw101_beats", 32'(beats), 32'd2);
        checkOutput("lw101_addr0", beatAddr[0], 32'h100);
        checkOutput("lw101_be0", 32'(beatBe[0]), 32'hE);
        checkOutput("lw101_addr1", beatAddr[1], 32'h104);
        checkOutput("lw101_be1", 32'(beatBe[1]), 32'h1);
        checkOutput("lw101_rdata", resRdata, 32'h55443322);
`else
        checkOutput("lw101_mis_cyc", 32'(resMisCyc), 32'd1);
        checkOutput("lw101_no_req", 32'(beats), 32'd0);
        checkOutput("lw101_stall_after", 32'(termStall), 32'd0);
`endif
        applyStimulus(1, 0, 3'b001, 0, 32'h101, 32'h0, 0, 1, 32'hAABBCCDD, 32'h0);
`ifdef LSU_MISALIGNED_SPLIT_EN
        checkOutput("lh101_done_cyc", 32'(resDoneCyc), 32'd3);
        checkOutput("lh101_be", 32'(beatBe[0]), 32'h6);
        checkOutput("lh101_rdata", resRdata, 32'hFFFFBBCC);
`else
        checkOutput("lh101_mis_cyc", 32'(resMisCyc), 32'd1);
        checkOutput("lh101_no_req", 32'(beats), 32'd0);
`endif
        applyStimulus(0, 1, 3'b010, 0, 32'h502, 32'h11223344, 0, 1, 32'h0, 32'h0);
`ifdef LSU_MISALIGNED_SPLIT_EN
        checkOutput("sw502_done_cyc", 32'(resDoneCyc), 32'd5);
        checkOutput("sw502_wdata0", beatWdata[0], 32'h33440000);
        checkOutput("sw502_be0", 32'(beatBe[0]), 32'hC);
        checkOutput("sw502_wdata1", beatWdata[1], 32'h00001122);
        checkOutput("sw502_be1", 32'(beatBe[1]), 32'h3);
        checkOutput("sw502_addr1", beatAddr[1], 32'h504);
`else
        checkOutput("sw502_mis_cyc", 32'(resMisCyc), 32'd1);
        checkOutput("sw502_no_req", 32'(beats), 32'd0);
`endif

        // Timeout: granted but never answered
        applyStimulus(1, 0, 3'b010, 0, 32'h600, 32'h0, 0, 0, 32'h0, 32'h0);
        checkOutput("timeout_cyc", 32'(resBusCyc), 32'd18);
        checkOutput("timeout_stall", 32'(termStall), 32'd0);
        checkOutput("timeout_no_done", 32'(resDoneCyc), 32'hFFFFFFFF);

        // start with neither load nor store is ignored
        @(negedge clk);
        start = 1'b1; is_load = 1'b0; mem_write = 1'b0;
        #1;
        checkOutput("noop_stall", 32'(stall), 32'd0);
        @(negedge clk);
        start = 1'b0;
        checkOutput("noop_req", 32'(mem_req), 32'd0);

        // Reset while waiting in WAIT0
        @(negedge clk);
        start = 1'b1; is_load = 1'b1; load_type = 3'b010; addr = 32'h700;
        @(posedge clk);
        #1;
        start = 1'b0; is_load = 1'b0;
        @(negedge clk);
        checkOutput("rst_req_before", 32'(mem_req), 32'd1);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        checkOutput("rst_stall_wait0", 32'(stall), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_req_async", 32'(mem_req), 32'd0);
        checkOutput("rst_stall_async", 32'(stall), 32'd0);
        @(negedge clk);
        checkOutput("rst_no_done", 32'({done, misalign_err, bus_err}), 32'd0);
        checkOutput("rst_rdata_cleared", rdata_out, 32'h0);
        rst_n = 1'b1;

        // Recovery after reset
        applyStimulus(1, 0, 3'b010, 0, 32'h800, 32'h0, 0, 1, 32'h0BADF00D, 32'h0);
        checkOutput("post_rst_rdata", resRdata, 32'h0BADF00D);
        checkOutput("post_rst_done_cyc", 32'(resDoneCyc), 32'd3);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/lsu_controller.md
Name: lsu_controller

Overview:
- Load/store unit sequencer between the decode/execute stage of the 3-stage RISC-V pipeline and a 32-bit word-addressed data memory port.
- Takes decoded memory-op controls plus the ALU-computed address and store data.
- Drives a req/gnt/rvalid memory handshake, generates byte enables and lane-shifted store data, extracts and extends load data, and stalls the pipeline until the access completes.

Parameters:
- TIMEOUT_CYCLES, 16, max cycles waiting for mem_gnt or mem_rvalid before bus_err; 0 disables the timeout.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous reset, active-low
- start  in  1  valid memory op presented this cycle
- is_load  in  1  op is a load
- mem_write  in  1  op is a store
- load_type  in  3  000 byte, 001 half, 010 word; other codes = word
- load_unsigned  in  1  zero-extend load result
- store_type  in  3  store width, same encoding as load_type
- addr  in  32  byte address from ALU
- wdata  in  32  store data (rs2)
- stall  out  1  hold pipeline
- done  out  1  one-cycle completion pulse
- rdata_out  out  32  extended load result, valid when done=1
- misalign_err  out  1  one-cycle pulse: access rejected
- bus_err  out  1  one-cycle pulse: timeout
- mem_req  out  1  memory request
- mem_we  out  1  write strobe
- mem_addr  out  32  word-aligned address, bits [1:0]=00
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-aligned write data
- mem_gnt  in  1  request accepted
- mem_rvalid  in  1  response / write ack, earliest one cycle after gnt
- mem_rdata  in  32  read data, valid with rvalid

Behaviour:
- Reset: state IDLE; all outputs 0. rdata_out resets to 0.
- Asserting rst_n low mid-operation forces IDLE immediately and drops mem_req asynchronously. No done or error pulse is produced.
- States: IDLE, REQ0, WAIT0, REQ1, WAIT1, DONE.
- Access width:
  - Size is 1, 2 or 4 bytes, from load_type when is_load=1, otherwise from store_type.
  - is_load has priority if both is_load and mem_write are high.
  - start with neither set is ignored.
- Alignment:
  - off = addr[1:0].
  - mask = (1<<size)-1, shifted left by off into an 8-bit window.
  - The access crosses a word boundary when off+size > 4.
- IDLE:
  - On start (load or store): stall=1 combinationally in the same cycle.
  - Op, address, data and width are captured at that edge; next state REQ0.
  - If the access is rejected (see Optional Feature): misalign_err pulses the following cycle and the controller returns to IDLE with no memory access.
- REQ0:
  - mem_req=1, mem_addr={addr[31:2],2'b00}, mem_be=window[3:0], mem_wdata=wdata<<(8*off), mem_we=store.
  - All signals are held stable until mem_gnt; on gnt go to WAIT0.
- WAIT0:
  - mem_req=0. On mem_rvalid, capture mem_rdata as the low word.
  - Next state is REQ1 if the access crosses a word boundary, else DONE.
- REQ1:
  - mem_addr = previous word address + 4; mem_be=window[7:4]; mem_wdata=wdata>>(32-8*off).
  - Same handshake as REQ0; on gnt go to WAIT1.
- WAIT1: on mem_rvalid, capture the high word; go to DONE.
- DONE:
  - done=1, stall=0.
  - For loads, rdata_out = ({hi,lo}>>(8*off)) truncated to size, then sign- or zero-extended; it is held until the next done. Stores leave rdata_out unchanged.
  - Next state IDLE. A start in this cycle is ignored; the pipeline advances on this edge.
- stall = 1 whenever state is not IDLE or DONE, plus the combinational start-in-IDLE case.
- Latency with a zero-wait memory (gnt in the request cycle, rvalid the next cycle): done 3 cycles after start; a split access takes 5.
- Timeout:
  - A counter resets on each state entry and increments in REQx/WAITx.
  - On reaching TIMEOUT_CYCLES: bus_err pulses one cycle, mem_req drops, state returns to IDLE and stall deasserts.
- mem_rvalid outside WAITx and mem_gnt outside REQx are ignored.

Optional Feature:
- Macro: LSU_MISALIGNED_SPLIT_EN.
- Defined: naturally misaligned accesses are performed. Non-crossing accesses (e.g. half at off=1) take one beat; crossing accesses take two beats via REQ1/WAIT1.
- Undefined:
  - Accesses are rejected when half has off[0]=1 or word has off≠0. Rejection gives misalign_err one cycle after start, then IDLE.
  - REQ1/WAIT1 are not built.

Test Plan:
- LW addr=0x100, memory returns 0xDEADBEEF (gnt immediate, rvalid +1) -> mem_be=1111, done 3 cycles after start, rdata_out=0xDEADBEEF, stall high for 3 cycles.
- LB addr=0x103, mem_rdata=0x80FFFFFF -> rdata_out=0xFFFFFF80. LBU at the same address -> 0x00000080.
- SH addr=0x102, wdata=0x0000ABCD -> mem_we=1, mem_be=1100, mem_wdata=0xABCD0000, rdata_out unchanged.
- mem_gnt delayed 4 cycles -> mem_req and mem_addr stay stable, stall held throughout, done 7 cycles after start.
- LW addr=0x101:
  - With the macro: two beats at 0x100 (be=1110) and 0x104 (be=0001); memory words 0x44332211/0x88776655 -> rdata_out=0x55443322.
  - Without the macro: misalign_err pulse, mem_req never asserted.
- No rvalid with TIMEOUT_CYCLES=16 -> bus_err pulse, IDLE. Asserting rst_n low mid-WAIT0 -> mem_req=0, stall=0 immediately.
